// File: rtl/sram_bridge_32to16_if.sv
// LSU-side word port of the 32-to-16 SRAM bridge; the core drives the master
// modport, and the bridge answers on the slave modport with ack/stall/rdata.
`timescale 1ns/1ps
interface sram_bridge_32to16_if;
   logic        i_rd;
   logic        i_wr;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [3:0]  i_bmask;
   logic [31:0] o_rdata;
   logic        o_ack;
   logic        o_stall;

   modport master (
      output i_rd, i_wr, i_addr, i_wdata, i_bmask,
      input  o_rdata, o_ack, o_stall
   );

   modport slave (
      input  i_rd, i_wr, i_addr, i_wdata, i_bmask,
      output o_rdata, o_ack, o_stall
   );
endinterface

// File: rtl/sram_bridge_32to16.sv
// Splits 32-bit LSU accesses into two 16-bit SRAM cycles, with ack 4 cycles after the request and stall held meanwhile.
// Defining SRAM_HALF_SKIP_EN skips write halves whose byte mask is empty.
`timescale 1ns/1ps
module sram_bridge_32to16 #(
   parameter int          ADDR_W    = 18,
   parameter logic [31:0] RDATA_RST = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   sram_bridge_32to16_if.slave lsu,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [15:0]       SRAM_D,
   input  logic [15:0]       SRAM_Q,
   output logic              SRAM_CE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_UB_N
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-2:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_bmask;
   logic              r_we;
   logic [15:0]       r_rlo;
   logic [31:0]       r_rdata;

   logic w_req;
   logic w_in_lo;
   logic w_in_hi;
   logic w_r_hi;
   logic w_ack;
   logic w_stall;
   logic w_hi_sel;
   logic [1:0] w_mask;
   logic w_unused_addr;

   assign w_req         = lsu.i_rd | lsu.i_wr;
   assign w_unused_addr = ^{lsu.i_addr[31:ADDR_W+1], lsu.i_addr[1:0]};

`ifdef SRAM_HALF_SKIP_EN
   // Reads always run both halves; only empty write halves are dropped.
   assign w_in_lo = ~lsu.i_wr | (|lsu.i_bmask[1:0]);
   assign w_in_hi = ~lsu.i_wr | (|lsu.i_bmask[3:2]);
   assign w_r_hi  = ~r_we | (|r_bmask[3:2]);
`else
   assign w_in_lo = 1'b1;
   assign w_in_hi = 1'b1;
   assign w_r_hi  = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_bmask <= '0;
         r_we    <= 1'b0;
         r_rlo   <= '0;
         r_rdata <= RDATA_RST;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_req) begin
            r_addr  <= lsu.i_addr[ADDR_W:2];
            r_wdata <= lsu.i_wdata;
            r_bmask <= lsu.i_bmask;
            r_we    <= lsu.i_wr;
         end
         // Low half is parked so o_rdata only changes when the whole word is in.
         if (r_state == S_LO && !r_we)
            r_rlo <= SRAM_Q;
         if (r_state == S_HI && !r_we)
            r_rdata <= {SRAM_Q, r_rlo};
      end
   end

   assign w_hi_sel = (r_state == S_HI);
   assign w_mask   = w_hi_sel ? r_bmask[3:2] : r_bmask[1:0];

   always_comb begin
      w_next    = r_state;
      w_ack     = 1'b0;
      w_stall   = 1'b0;
      SRAM_ADDR = '0;
      SRAM_D    = '0;
      SRAM_CE_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_UB_N = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_stall = w_req & reset;
            if (w_req)
               w_next = w_in_lo ? S_LO : (w_in_hi ? S_HI : S_DONE);
         end
         S_LO, S_HI: begin
            w_stall   = 1'b1;
            w_next    = (r_state == S_HI || !w_r_hi) ? S_DONE : S_HI;
            SRAM_ADDR = {r_addr, w_hi_sel};
            SRAM_CE_N = 1'b0;
            if (r_we) begin
               SRAM_WE_N = 1'b0;
               SRAM_D    = w_hi_sel ? r_wdata[31:16] : r_wdata[15:0];
               SRAM_LB_N = ~w_mask[0];
               SRAM_UB_N = ~w_mask[1];
            end else begin
               SRAM_OE_N = 1'b0;
               SRAM_LB_N = 1'b0;
               SRAM_UB_N = 1'b0;
            end
         end
         S_DONE: begin
            w_ack  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign lsu.o_rdata = r_rdata;
   assign lsu.o_ack   = w_ack;
   assign lsu.o_stall = w_stall;

endmodule

// File: tb/tb_sram_bridge_32to16.sv
// Scoreboard bench for sram_bridge_32to16: a behavioural SRAM, a word-level shadow
// memory, and queues of expected SRAM cycles and acks checked as the DUT produces them.
`timescale 1ns/1ps
module tb_sram_bridge_32to16;
   localparam int ADDR_W = 18;
`ifdef SRAM_HALF_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sram_bridge_32to16_if lsu();

   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_d;
   logic [15:0]       sram_q;
   logic              ce_n, we_n, oe_n, lb_n, ub_n;

   sram_bridge_32to16 #(.ADDR_W(ADDR_W), .RDATA_RST(32'h0)) dut (
      .clk       (clk),
      .reset     (reset),
      .lsu       (lsu.slave),
      .SRAM_ADDR (sram_addr),
      .SRAM_D    (sram_d),
      .SRAM_Q    (sram_q),
      .SRAM_CE_N (ce_n),
      .SRAM_WE_N (we_n),
      .SRAM_OE_N (oe_n),
      .SRAM_LB_N (lb_n),
      .SRAM_UB_N (ub_n)
   );

   logic [15:0] mem [0:(1<<ADDR_W)-1] = '{default: 16'h0};
   assign sram_q = mem[sram_addr];
   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!lb_n) mem[sram_addr][7:0]  <= sram_d[7:0];
         if (!ub_n) mem[sram_addr][15:8] <= sram_d[15:8];
      end
   end

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we_n;
      logic              oe_n;
      logic              lb_n;
      logic              ub_n;
      logic [15:0]       d;
   } cyc_t;

   cyc_t        cyc_q[$];
   logic [31:0] ack_q[$];
   logic [31:0] shadow [int];
   logic [31:0] last_rdata = 32'h0;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (!ce_n) begin
            cyc_t e;
            chk("sram_cycle_expected", 64'(cyc_q.size() != 0), 64'd1);
            if (cyc_q.size() != 0) begin
               e = cyc_q.pop_front();
               chk("sram_ctl", {sram_addr, we_n, oe_n, lb_n, ub_n},
                   {e.addr, e.we_n, e.oe_n, e.lb_n, e.ub_n});
               if (!e.we_n) chk("sram_d", sram_d, e.d);
            end
         end
         if (lsu.o_ack) begin
            chk("ack_expected", 64'(ack_q.size() != 0), 64'd1);
            if (ack_q.size() != 0) chk("rdata_at_ack", lsu.o_rdata, ack_q.pop_front());
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_sram_ctl", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'b11111);
      chk("rst_sram_addr", sram_addr, 0);
      chk("rst_sram_d", sram_d, 0);
      chk("rst_stall", lsu.o_stall, 0);
      chk("rst_ack", lsu.o_ack, 0);
      chk("rst_rdata", lsu.o_rdata, 0);
   endtask

   // Called just after a posedge; returns just after the edge that leaves DONE.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] bm);
      int          key;
      int          halves;
      logic [31:0] prev;
      logic [31:0] cur;
      logic [1:0]  m;
      logic        got;
      cyc_t        c;
      key    = int'(a[ADDR_W:2]);
      prev   = last_rdata;
      halves = 0;
      got    = 1'b0;
      cur    = shadow.exists(key) ? shadow[key] : 32'h0;
      for (int h = 0; h < 2; h++) begin
         m = bm[2*h +: 2];
         c.addr = {a[ADDR_W:2], h[0]};
         if (wr) begin
            if (SKIP && m == 2'b00) continue;
            c.we_n = 1'b0; c.oe_n = 1'b1; c.lb_n = ~m[0]; c.ub_n = ~m[1];
            c.d = wd[16*h +: 16];
         end else begin
            c.we_n = 1'b1; c.oe_n = 1'b0; c.lb_n = 1'b0; c.ub_n = 1'b0;
            c.d = 16'h0;
         end
         cyc_q.push_back(c);
         halves++;
      end
      if (wr) begin
         for (int b = 0; b < 4; b++) if (bm[b]) cur[8*b +: 8] = wd[8*b +: 8];
         shadow[key] = cur;
      end else begin
         last_rdata = cur;
      end
      ack_q.push_back(last_rdata);
      lsu.i_rd = rd; lsu.i_wr = wr; lsu.i_addr = a; lsu.i_wdata = wd; lsu.i_bmask = bm;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (lsu.o_ack) begin
            chk("ack_cycle", n, 2 + halves);
            chk("stall_in_done", lsu.o_stall, 0);
            got = 1'b1;
            break;
         end
         chk("stall_busy", lsu.o_stall, 1);
         chk("rdata_hold", lsu.o_rdata, prev);
      end
      if (!got) chk("ack_timeout", got, 1);
      @(posedge clk); #1;
      lsu.i_rd = 1'b0; lsu.i_wr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      lsu.i_rd = 1'b0; lsu.i_wr = 1'b1;
      lsu.i_addr = 32'h0; lsu.i_wdata = 32'h0; lsu.i_bmask = 4'h0;
      repeat (2) @(negedge clk);
      check_reset_state();
      lsu.i_wr = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      access(1'b0, 1'b1, 32'h10, 32'h00550000, 4'b0100);
      access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

      // Reset lands in HI of a store: LO half is already in SRAM, HI is not.
      cyc_q.push_back('{addr: 18'h010, we_n: 1'b0, oe_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0, d: 16'h2222});
      lsu.i_wr = 1'b1; lsu.i_addr = 32'h20; lsu.i_wdata = 32'h11112222; lsu.i_bmask = 4'hF;
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state();
      shadow[8] = 32'h00002222;
      last_rdata = 32'h0;
      lsu.i_wr = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

      access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
      access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      access(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      access(1'b0, 1'b1, 32'h80014, 32'hFFFFABCD, 4'b0011);
      access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
      access(1'b0, 1'b1, 32'h7FFFC, 32'h13579BDF, 4'hF);
      access(1'b1, 1'b0, 32'h7FFFC, 32'h0, 4'h0);
      access(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b1000);
      access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);

      repeat (2) @(negedge clk);
      chk("sram_q_drained", cyc_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
